morph_window_3x3: RTL
=====================

MORPH_WINDOW_3X3 -- requirements
Module: morph_window_3x3

Interface
REQ-001 SHALL have parameter PIC_WIDTH, default 11'd250, pixels per row.
REQ-002 SHALL have parameter PIC_HEIGHT, default 11'd250, rows per frame.
REQ-003 SHALL have parameter WIDTH, default 24, pixel data width (unsigned).
REQ-004 SHALL have parameter RST_CYCLES, default 8, rst_fifo low-pulse length.
REQ-005 clk  input  1  single clock, all logic on posedge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 frame_start  input  1  one-cycle start pulse, honoured only in IDLE.
REQ-008 op_sel  input  1  0 = erosion (min of 9), 1 = dilation (max of 9); sampled at frame_start.
REQ-009 valid_in  input  1  upstream pixel strobe; the pixel itself goes straight to the line buffer din.
REQ-010 in_ready  output  1  high in RUN only; upstream asserts valid_in only while in_ready=1.
REQ-011 lb_wr_en  output  1  line-buffer write enable = valid_in & in_ready.
REQ-012 rst_fifo  output  1  line-buffer FIFO reset, active-low.
REQ-013 fifo_rst_busy  input  1  line-buffer reset-busy flag.
REQ-014 rd_en_all  output  1  line-buffer global read enable.
REQ-015 din1, din2, din3  input  WIDTH each  line-buffer taps; rows r-1, r-2, r-3; column aligned; valid 1 cycle after rd_en_all.
REQ-016 dout  output  WIDTH  morphological result.
REQ-017 valid_out  output  1  dout valid strobe.
REQ-018 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-019 SHALL implement FSM IDLE -> FIFO_RST -> WAIT_BUSY -> RUN -> DRAIN -> DONE -> IDLE.
REQ-020 IDLE: frame_start=1 -> FIFO_RST next cycle, latch op_sel, clear all counters and window.
REQ-021 FIFO_RST: rst_fifo=0 for exactly RST_CYCLES cycles, then WAIT_BUSY.
REQ-022 WAIT_BUSY: rst_fifo=1; leave for RUN on the first cycle fifo_rst_busy=0.
REQ-023 RUN: lb_wr_en advances col counter in_col (0..PIC_WIDTH-1, wrap to 0 and increment in_row).
REQ-024 RUN: rd_en_all = lb_wr_en & (in_row >= 3).
REQ-025 RUN: on lb_wr_en with in_col=PIC_WIDTH-1 and in_row=PIC_HEIGHT-1 -> DRAIN.
REQ-026 DRAIN: rd_en_all=1 for exactly PIC_WIDTH consecutive cycles (flushes last row), lb_wr_en=0, then DONE.
REQ-027 DONE: frame_done=1 for one cycle, then IDLE once the compare pipeline is empty.
REQ-028 tap_valid SHALL be rd_en_all delayed 1 cycle; on tap_valid the 3x3 window shifts left one column, loading {din3,din2,din1} as new right column.
REQ-029 win_col counter (0..PIC_WIDTH-1) SHALL count tap_valid, wrapping per row; window is complete when win_col >= 2 after the shift.
REQ-030 Result SHALL be min (op_sel=0) or max (op_sel=1) of the 9 window pixels, computed in a 2-stage registered compare tree.
REQ-031 valid_out SHALL assert exactly 2 cycles after each tap_valid that completes a window; 3 cycles after the triggering rd_en_all.
REQ-032 Outputs SHALL cover interior pixels only: (PIC_WIDTH-2) per row, (PIC_HEIGHT-2) rows, raster order; no border replication.
REQ-033 Window SHALL not mix rows: win_col restart at 0 discards previous-row columns for completeness.
REQ-034 valid_in outside RUN SHALL be ignored (no counter change, lb_wr_en=0).
REQ-035 frame_start outside IDLE SHALL be ignored.
REQ-036 Gaps in valid_in SHALL stall counters and window with no output corruption.

Reset
REQ-037 rst_n=0 SHALL asynchronously force IDLE, rst_fifo=1, in_ready=0, lb_wr_en=0, rd_en_all=0, valid_out=0, frame_done=0, dout=0, counters and window 0.
REQ-038 rst_n asserted mid-frame SHALL abort the frame; the next frame begins only with frame_start and a fresh FIFO_RST.

Verification
REQ-039 PIC_WIDTH=8, PIC_HEIGHT=6, ramp pixels, op_sel=0 -> exactly 24 valid_out, each = top-left window pixel, frame_done once.
REQ-040 Same frame, op_sel=1 -> 24 outputs, each = bottom-right window pixel (value centre+PIC_WIDTH+1).
REQ-041 frame_start -> rst_fifo low 8 cycles; fifo_rst_busy held high 5 more cycles -> in_ready rises the cycle after busy falls.
REQ-042 Single pixel 0 in all-255 frame, op_sel=0 -> exactly 9 outputs equal 0, rest 255.
REQ-043 valid_in randomly deasserted 50% -> output sequence identical to REQ-039 case.
REQ-044 rst_n pulsed low mid-RUN -> all outputs at reset values immediately; next frame_start yields full 24-output frame.

Source files
------------

// File: rtl/morph_window_3x3.sv
// 3x3 grey-scale erosion/dilation over an external three-tap line buffer.
// Sequences the FIFO reset, counts pixels in and windows out, and reduces each window to its min or max.
module morph_window_3x3 #(
    parameter logic [10:0] PIC_WIDTH  = 11'd250,
    parameter logic [10:0] PIC_HEIGHT = 11'd250,
    parameter int          WIDTH      = 24,
    parameter int          RST_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             op_sel,
    input  logic             valid_in,
    output logic             in_ready,
    output logic             lb_wr_en,
    output logic             rst_fifo,
    input  logic             fifo_rst_busy,
    output logic             rd_en_all,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [WIDTH-1:0] dout,
    output logic             valid_out,
    output logic             frame_done
);

    localparam int PW = int'(PIC_WIDTH);
    localparam int PH = int'(PIC_HEIGHT);
    localparam int CW = (PW > 1) ? $clog2(PW) : 1;
    localparam int RW = (PH > 1) ? $clog2(PH) : 1;
    localparam int KW = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FIFO_RST,
        WAIT_BUSY,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]           in_col;
    logic [RW-1:0]           in_row;
    logic [CW-1:0]           win_col;
    logic [KW-1:0]           rst_cnt;
    logic                    op_q;
    logic                    tap_valid;
    logic                    red_valid;
    logic [2:0][WIDTH-1:0]   col_red;
    logic                    pipe_busy;
    logic                    start_ok;

    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             take_max);
        if (take_max)
            return (a > b) ? a : b;
        return (a < b) ? a : b;
    endfunction

    assign pipe_busy = tap_valid | red_valid | valid_out;
    assign start_ok  = (state == IDLE) && frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        lb_wr_en   = 1'b0;
        rst_fifo   = 1'b1;
        rd_en_all  = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start)
                    state_nxt = FIFO_RST;
            end
            FIFO_RST: begin
                rst_fifo = 1'b0;
                if (rst_cnt == KW'(RST_CYCLES - 1))
                    state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!fifo_rst_busy)
                    state_nxt = RUN;
            end
            RUN: begin
                in_ready  = 1'b1;
                lb_wr_en  = valid_in;
                rd_en_all = valid_in && (in_row >= RW'(3));
                if (valid_in && (in_col == CW'(PW - 1)) && (in_row == RW'(PH - 1)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                rd_en_all = 1'b1;
                if (in_col == CW'(PW - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                // Hold off the done pulse until the last window has left the compare tree.
                if (!pipe_busy) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input-side counters; in_col doubles as the drain length counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_col  <= '0;
            in_row  <= '0;
            rst_cnt <= '0;
            op_q    <= 1'b0;
        end else if (start_ok) begin
            in_col  <= '0;
            in_row  <= '0;
            rst_cnt <= '0;
            op_q    <= op_sel;
        end else if (state == FIFO_RST) begin
            rst_cnt <= rst_cnt + KW'(1);
        end else if (lb_wr_en) begin
            if (in_col == CW'(PW - 1)) begin
                in_col <= '0;
                in_row <= (in_row == RW'(PH - 1)) ? '0 : in_row + RW'(1);
            end else begin
                in_col <= in_col + CW'(1);
            end
        end else if (state == DRAIN) begin
            in_col <= (in_col == CW'(PW - 1)) ? '0 : in_col + CW'(1);
        end
    end

    // The window holds each column already reduced over its three rows, which is the first compare stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_valid <= 1'b0;
            red_valid <= 1'b0;
            win_col   <= '0;
            col_red   <= '0;
        end else begin
            tap_valid <= rd_en_all;
            if (start_ok) begin
                red_valid <= 1'b0;
                win_col   <= '0;
                col_red   <= '0;
            end else if (tap_valid) begin
                col_red[0] <= col_red[1];
                col_red[1] <= col_red[2];
                col_red[2] <= pick(pick(din1, din2, op_q), din3, op_q);
                red_valid  <= (win_col >= CW'(2));
                win_col    <= (win_col == CW'(PW - 1)) ? '0 : win_col + CW'(1);
            end else begin
                red_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            dout      <= '0;
        end else begin
            valid_out <= red_valid;
            if (red_valid)
                dout <= pick(pick(col_red[0], col_red[1], op_q), col_red[2], op_q);
        end
    end

endmodule
